// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between IF and MEM with a global stall.
// Define MEMARB_RR_EN to alternate grants when both requesters are pending.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_valid,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ack,
  input  logic [DW-1:0] m_rdata,
  output logic          stall
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IF  = 2'd1,
    GNT_MEM = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          m_req_q, m_req_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] mem_rdata_q, mem_rdata_d;
  logic          if_served_q, if_served_d;
  logic          mem_served_q, mem_served_d;
  logic          pend_if, pend_mem, sel_mem;

  assign pend_if  = if_req & ~if_served_q;
  assign pend_mem = mem_req & ~mem_served_q;
  assign stall    = pend_if | pend_mem;

`ifdef MEMARB_RR_EN
  // last_gnt: 0 = IF, 1 = MEM
  logic last_gnt_q, last_gnt_d;
  assign sel_mem = pend_mem & (~pend_if | ~last_gnt_q);

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (state_q == IDLE && sel_mem) begin
      last_gnt_d = 1'b1;
    end else if (state_q == IDLE && pend_if) begin
      last_gnt_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) last_gnt_q <= 1'b0;
    else       last_gnt_q <= last_gnt_d;
  end
`else
  assign sel_mem = pend_mem;
`endif

  always_comb begin
    state_d      = state_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_served_d  = if_served_q;
    mem_served_d = mem_served_q;

    if (!stall) begin
      if_served_d  = 1'b0;
      mem_served_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (sel_mem) begin
          state_d   = GNT_MEM;
          m_req_d   = 1'b1;
          m_we_d    = mem_we;
          m_addr_d  = mem_addr;
          m_wdata_d = mem_wdata;
        end else if (pend_if) begin
          state_d   = GNT_IF;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = if_addr;
          m_wdata_d = mem_wdata;
        end
      end
      GNT_IF: begin
        if (m_ack) begin
          state_d     = IDLE;
          m_req_d     = 1'b0;
          if_served_d = 1'b1;
          if_rdata_d  = m_rdata;
        end
      end
      GNT_MEM: begin
        if (m_ack) begin
          state_d      = IDLE;
          m_req_d      = 1'b0;
          mem_served_d = 1'b1;
          if (!m_we_q) mem_rdata_d = m_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_served_q  <= 1'b0;
      mem_served_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_served_q  <= if_served_d;
      mem_served_q <= mem_served_d;
    end
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_valid  = if_served_q;
  assign mem_valid = mem_served_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; follows MEMARB_RR_EN for grant order.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        stall;

  int n_chk  = 0;
  int n_pass = 0;
  bit first_mem;
  logic [31:0] a1, a2;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .m_req(m_req), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .stall(stall)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // inputs change at the falling edge; checks settle 1 time unit later
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b1; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_wdata = '0;
    m_ack = 1'b0; m_rdata = '0;
    cyc(); cyc(); cyc(); #1;
    chk("rst m_req", {31'd0, m_req}, 32'd0);
    chk("rst m_we", {31'd0, m_we}, 32'd0);
    chk("rst m_addr", m_addr, 32'd0);
    chk("rst m_wdata", m_wdata, 32'd0);
    chk("rst if_rdata", if_rdata, 32'd0);
    chk("rst mem_rdata", mem_rdata, 32'd0);
    chk("rst if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst stall", {31'd0, stall}, 32'd1);
    if_req = 1'b0; #1;
    chk("rst stall idle", {31'd0, stall}, 32'd0);
    cyc(); reset = 1'b0;
    cyc();

    // fetch, ack in first request cycle
    if_req = 1'b1; if_addr = 32'h40; #1;
    chk("f c0 stall", {31'd0, stall}, 32'd1);
    chk("f c0 m_req", {31'd0, m_req}, 32'd0);
    cyc(); m_ack = 1'b1; m_rdata = 32'h2010_0005; #1;
    chk("f c1 m_req", {31'd0, m_req}, 32'd1);
    chk("f c1 m_addr", m_addr, 32'h40);
    chk("f c1 m_we", {31'd0, m_we}, 32'd0);
    chk("f c1 stall", {31'd0, stall}, 32'd1);
    cyc(); m_ack = 1'b0; m_rdata = '0; #1;
    chk("f c2 if_valid", {31'd0, if_valid}, 32'd1);
    chk("f c2 if_rdata", if_rdata, 32'h2010_0005);
    chk("f c2 stall", {31'd0, stall}, 32'd0);
    chk("f c2 m_req", {31'd0, m_req}, 32'd0);
    cyc(); if_req = 1'b0; #1;
    chk("f c3 if_valid", {31'd0, if_valid}, 32'd0);
    chk("f c3 if_rdata", if_rdata, 32'h2010_0005);
    cyc();

    // store, three memory wait cycles
    mem_req = 1'b1; mem_we = 1'b1;
    mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF; #1;
    chk("s c0 stall", {31'd0, stall}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      m_ack = (i == 4);
      m_rdata = (i == 4) ? 32'h1234_5678 : 32'h0;
      #1;
      chk($sformatf("s c%0d m_req", i), {31'd0, m_req}, 32'd1);
      chk($sformatf("s c%0d m_we", i), {31'd0, m_we}, 32'd1);
      chk($sformatf("s c%0d m_addr", i), m_addr, 32'h100);
      chk($sformatf("s c%0d m_wdata", i), m_wdata, 32'hDEAD_BEEF);
      chk($sformatf("s c%0d stall", i), {31'd0, stall}, 32'd1);
    end
    cyc(); m_ack = 1'b0; m_rdata = '0; #1;
    chk("s c5 mem_valid", {31'd0, mem_valid}, 32'd1);
    chk("s c5 stall", {31'd0, stall}, 32'd0);
    chk("s c5 mem_rdata", mem_rdata, 32'd0);
    cyc(); mem_req = 1'b0; mem_we = 1'b0; #1;
    chk("s c6 mem_valid", {31'd0, mem_valid}, 32'd0);
    cyc();

    // simultaneous load and fetch; last grant was MEM
`ifdef MEMARB_RR_EN
    first_mem = 1'b0;
`else
    first_mem = 1'b1;
`endif
    a1 = first_mem ? 32'h200 : 32'h44;
    a2 = first_mem ? 32'h44 : 32'h200;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h44; #1;
    chk("b c0 stall", {31'd0, stall}, 32'd1);
    cyc(); m_ack = 1'b1; m_rdata = 32'hAAAA_0001; #1;
    chk("b c1 m_req", {31'd0, m_req}, 32'd1);
    chk("b c1 m_addr", m_addr, a1);
    chk("b c1 m_we", {31'd0, m_we}, 32'd0);
    cyc(); m_ack = 1'b0; m_rdata = '0; #1;
    chk("b c2 m_req gap", {31'd0, m_req}, 32'd0);
    chk("b c2 stall", {31'd0, stall}, 32'd1);
    chk("b c2 mem_valid", {31'd0, mem_valid}, {31'd0, first_mem});
    chk("b c2 if_valid", {31'd0, if_valid}, {31'd0, ~first_mem});
    cyc(); m_ack = 1'b1; m_rdata = 32'hBBBB_0002; #1;
    chk("b c3 m_req", {31'd0, m_req}, 32'd1);
    chk("b c3 m_addr", m_addr, a2);
    chk("b c3 stall", {31'd0, stall}, 32'd1);
    cyc(); m_ack = 1'b0; m_rdata = '0; #1;
    chk("b c4 stall", {31'd0, stall}, 32'd0);
    chk("b c4 mem_valid", {31'd0, mem_valid}, 32'd1);
    chk("b c4 if_valid", {31'd0, if_valid}, 32'd1);
    chk("b c4 mem_rdata", mem_rdata,
        first_mem ? 32'hAAAA_0001 : 32'hBBBB_0002);
    chk("b c4 if_rdata", if_rdata,
        first_mem ? 32'hBBBB_0002 : 32'hAAAA_0001);
    cyc(); mem_req = 1'b0; if_req = 1'b0; #1;
    chk("b c5 mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("b c5 if_valid", {31'd0, if_valid}, 32'd0);
    cyc();

    // reset pulse during GNT_MEM, late ack
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300; #1;
    cyc(); reset = 1'b1; #1;
    chk("r c1 m_req", {31'd0, m_req}, 32'd1);
    cyc(); reset = 1'b0; m_ack = 1'b1; m_rdata = 32'h9999_9999; #1;
    chk("r c2 m_req", {31'd0, m_req}, 32'd0);
    chk("r c2 stall", {31'd0, stall}, 32'd1);
    chk("r c2 mem_rdata", mem_rdata, 32'd0);
    cyc(); m_ack = 1'b0; m_rdata = '0; #1;
    chk("r c3 mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("r c3 mem_rdata", mem_rdata, 32'd0);
    chk("r c3 m_req", {31'd0, m_req}, 32'd1);
    chk("r c3 m_addr", m_addr, 32'h300);
    cyc(); m_ack = 1'b1; m_rdata = 32'h5555_0003; #1;
    cyc(); m_ack = 1'b0; m_rdata = '0; #1;
    chk("r c5 mem_valid", {31'd0, mem_valid}, 32'd1);
    chk("r c5 mem_rdata", mem_rdata, 32'h5555_0003);
    chk("r c5 stall", {31'd0, stall}, 32'd0);
    cyc(); mem_req = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
